// File: rtl/acq_sequencer.sv
// acq_sequencer
//   AXI4-Lite master that runs one acquisition on the data_read peripheral:
//   it writes CTRL = {MODE, 1}, polls STATUS until bit 0 is set, then reads
//   NWORDS words from DATA and hands each one to a valid/ready output stream.
//   Every AXI wait phase is bounded by TIMEOUT cycles. The STATUS poll loop
//   shares one budget across all of its polls.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET   clock, asynchronous active-high reset
//   START, MODE, NWORDS        acquisition request (accepted only when idle)
//   BUSY, DONE, ERR_CODE       status: 00 ok, 01 slave error, 10 timeout
//   M_AXI_AW*/W*/B*/AR*/R*     AXI4-Lite master channels
//   DOUT, DOUT_VALID/READY     captured-word stream
module acq_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1000
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        START,
  input  logic [1:0]  MODE,
  input  logic [7:0]  NWORDS,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  ERR_CODE,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  input  logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic        M_AXI_RVALID,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic [31:0] M_AXI_RDATA,
  output logic        M_AXI_RREADY,
  output logic [31:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_CTRL, WR_RESP, ST_ADDR, ST_DATA, RD_ADDR, RD_DATA, OUT, FINISH
  } state_t;

  state_t      state, state_next;
  logic [1:0]  mode_q;
  logic [7:0]  word_cnt;
  logic [1:0]  err_code, err_next;
  logic        aw_done, w_done;
  logic [31:0] dout_q;
  logic        dout_valid_q;
  logic [31:0] timer;
  logic        waiting, next_waiting, in_poll, next_in_poll, stay, timer_restart;

  // Next-state and AXI handshake outputs. The valids are pure functions of
  // the state, so leaving a wait state (including on timeout) drops them.
  always_comb begin
    state_next    = state;
    err_next      = err_code;
    M_AXI_AWADDR  = 32'h0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = 32'h0;
    M_AXI_WSTRB   = 4'h0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = 32'h0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    waiting       = 1'b0;
    in_poll       = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_next = WR_CTRL;
          err_next   = 2'b00;
        end
      end
      WR_CTRL: begin
        waiting       = 1'b1;
        M_AXI_AWADDR  = BASE_ADDR;
        M_AXI_AWVALID = !aw_done;
        M_AXI_WDATA   = {29'b0, mode_q, 1'b1};
        M_AXI_WSTRB   = 4'hF;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        waiting      = 1'b1;
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            err_next   = 2'b01;
            state_next = FINISH;
          end else begin
            state_next = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        waiting       = 1'b1;
        in_poll       = 1'b1;
        M_AXI_ARADDR  = BASE_ADDR + 32'h4;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        waiting      = 1'b1;
        in_poll      = 1'b1;
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            err_next   = 2'b01;
            state_next = FINISH;
          end else if (M_AXI_RDATA[0]) begin
            state_next = (word_cnt == 8'd0) ? FINISH : RD_ADDR;
          end else begin
            state_next = ST_ADDR;
          end
        end
      end
      RD_ADDR: begin
        waiting       = 1'b1;
        M_AXI_ARADDR  = BASE_ADDR + 32'h8;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_next = RD_DATA;
      end
      RD_DATA: begin
        waiting      = 1'b1;
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            err_next   = 2'b01;
            state_next = FINISH;
          end else begin
            state_next = OUT;
          end
        end
      end
      OUT: begin
        if (DOUT_READY) state_next = (word_cnt == 8'd1) ? FINISH : RD_ADDR;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Moving between ST_ADDR and ST_DATA still counts as the same wait phase,
    // otherwise a slave that always answers "not ready" would poll forever.
    next_in_poll = (state_next == ST_ADDR) || (state_next == ST_DATA);
    stay         = (state_next == state) || (in_poll && next_in_poll);
    if (waiting && stay && (timer >= TIMEOUT_LAST)) begin
      state_next = FINISH;
      err_next   = 2'b10;
    end

    next_in_poll  = (state_next == ST_ADDR) || (state_next == ST_DATA);
    timer_restart = (state_next != state) && !(in_poll && next_in_poll);
    next_waiting  = (state_next != IDLE) && (state_next != OUT) && (state_next != FINISH);
  end

  // State register.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_next;
  end

  // Datapath: request latches, write-channel acceptance flags, phase timer,
  // captured word and remaining-word counter.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      mode_q       <= 2'b00;
      word_cnt     <= 8'd0;
      err_code     <= 2'b00;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      dout_q       <= 32'h0;
      dout_valid_q <= 1'b0;
      timer        <= 32'h0;
    end else begin
      err_code <= err_next;
      if (timer_restart || !next_waiting) timer <= 32'h0;
      else                                timer <= timer + 32'd1;
      if (state == IDLE && START) begin
        mode_q   <= MODE;
        word_cnt <= NWORDS;
      end
      if (state == WR_CTRL && state_next == WR_CTRL) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == RD_DATA && M_AXI_RVALID && M_AXI_RRESP == 2'b00) begin
        dout_q       <= M_AXI_RDATA;
        dout_valid_q <= 1'b1;
      end
      if (state == OUT && DOUT_READY) begin
        dout_valid_q <= 1'b0;
        word_cnt     <= word_cnt - 8'd1;
      end
    end
  end

  assign BUSY       = (state != IDLE);
  assign DONE       = (state == FINISH) && (err_code == 2'b00);
  assign ERR_CODE   = err_code;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, data_read register base (CTRL=+0x0, STATUS=+0x4, DATA=+0x8).
REQ-002 SHALL have parameter TIMEOUT, default 1000, maximum M_AXI_ACLK cycles per AXI transaction or per STATUS poll phase.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 M_AXI_ACLK  in  1  sole clock, rising edge.
REQ-005 M_AXI_ARESET  in  1  asynchronous active-high reset.
REQ-006 START  in  1  one-cycle acquisition request; ignored unless IDLE.
REQ-007 MODE  in  2  value for CTRL[2:1], P12_SEL1/P12_SEL3 selection of data_read.
REQ-008 NWORDS  in  8  words to read from DATA (0 = none).
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 DONE  out  1  one-cycle pulse on successful completion.
REQ-011 ERR_CODE  out  2  00 none, 01 slave error response, 10 timeout; held until next START.
REQ-012 M_AXI_AWADDR/M_AXI_ARADDR  out  32  write/read address.
REQ-013 M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY  out  1 each  master handshakes.
REQ-014 M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID  in  1 each  slave handshakes.
REQ-015 M_AXI_WDATA  out  32; M_AXI_WSTRB  out  4 (always 4'hF during write).
REQ-016 M_AXI_BRESP, M_AXI_RRESP  in  2; M_AXI_RDATA  in  32.
REQ-017 DOUT  out  32; DOUT_VALID  out  1; DOUT_READY  in  1  captured-word stream.

Function
REQ-018 States: IDLE, WR_CTRL, WR_RESP, ST_ADDR, ST_DATA, RD_ADDR, RD_DATA, OUT, FINISH; IDLE+START -> WR_CTRL, latching MODE, NWORDS and clearing ERR_CODE.
REQ-019 WR_CTRL: AWADDR=BASE, WDATA={29'b0,MODE,1'b1}; AWVALID and WVALID asserted together, each deasserted independently on its READY; -> WR_RESP when both accepted.
REQ-020 WR_RESP: BREADY=1; on BVALID, BRESP!=00 -> ERR_CODE=01, FINISH; else -> ST_ADDR.
REQ-021 ST_ADDR: ARVALID=1, ARADDR=BASE+4 until ARREADY; ST_DATA: RREADY=1; on RVALID, RRESP!=00 -> error 01; RDATA[0]=1 -> RD_ADDR (or FINISH if NWORDS=0); else -> ST_ADDR (re-poll).
REQ-022 RD_ADDR/RD_DATA: same handshake at BASE+8; on accepted RVALID with RRESP=00, DOUT<=RDATA, DOUT_VALID<=1 next cycle, -> OUT.
REQ-023 OUT: DOUT/DOUT_VALID stable until DOUT_READY; on acceptance decrement word counter; counter=0 -> FINISH, else -> RD_ADDR.
REQ-024 FINISH: one cycle; DONE=1 only if ERR_CODE=00; writes CTRL=0 not performed; -> IDLE.
REQ-025 Timeout counter restarts on each state entry except ST_ADDR<->ST_DATA loop (counted jointly); reaching TIMEOUT in any AXI-waiting state -> ERR_CODE=10, all VALID/READY deasserted, FINISH; OUT never times out.
REQ-026 At most one outstanding AXI transaction; no VALID dropped before its READY except on timeout.
REQ-027 START while BUSY SHALL be ignored without side effect.

Reset
REQ-028 Asynchronous assertion of M_AXI_ARESET SHALL force IDLE, all VALID/READY/DONE/BUSY=0, ERR_CODE=00, DOUT=0, counters=0, even mid-transaction; release takes effect on next M_AXI_ACLK edge.

Verification
REQ-029 MODE=2'b10, NWORDS=3, STATUS ready on 2nd poll, DATA=0xA1,0xA2,0xA3 -> CTRL write 32'h5, 2 STATUS reads, 3 DATA reads, stream 0xA1,0xA2,0xA3, DONE pulse, ERR_CODE=00.
REQ-030 NWORDS=0, STATUS ready first poll -> no DATA read, DONE one cycle after STATUS RVALID handshake.
REQ-031 BRESP=2'b10 on CTRL write -> no AR issued, ERR_CODE=01, no DONE, BUSY low after FINISH.
REQ-032 STATUS never ready, TIMEOUT=50 -> ERR_CODE=10 within 51 cycles of first ST_ADDR, all VALIDs low.
REQ-033 DOUT_READY held low 20 cycles on word 2 -> DOUT stable, no AR during stall, all words delivered in order.
REQ-034 Reset asserted while AWVALID=1 -> outputs zero asynchronously; START after release runs a clean sequence.
